// File: rtl/axistream_forwarder.sv
// axistream_forwarder: streams a packetmem buffer out over AXI-Stream; define FWD_INORDER_SEL_EN to add the sel output
module axistream_forwarder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
  input  logic [DATA_WIDTH-1:0] forwarder_rd_data,
  output logic                  forwarder_rd_en,
  output logic                  forwarder_done,
  input  logic                  ready_for_forwarder,
  input  logic [ADDR_WIDTH:0]   len_to_forwarder,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
`ifdef FWD_INORDER_SEL_EN
  ,
  output logic                  sel
`endif
);
  localparam int PW = ADDR_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] len_q, reads, sent;
  logic [DATA_WIDTH-1:0] mem [2];
  logic head, inflight, hold, start, accept, push, pop;
  logic [1:0] count;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state, read issue and stream outputs; the head word bypasses the buffer when it is empty
  always_comb begin
    start = state == IDLE && ready_for_forwarder && !hold;
    forwarder_rd_en = state == STREAM && reads != len_q && (count + {1'b0, inflight}) < 2'd2;
    forwarder_rd_addr = forwarder_rd_en ? reads[ADDR_WIDTH-1:0] : '0;
    forwarder_done = state == DONE;
    m_axis_tvalid = state == STREAM && (count != 2'd0 || inflight);
    m_axis_tdata = !m_axis_tvalid ? '0 : count != 2'd0 ? mem[head] : forwarder_rd_data;
    m_axis_tlast = m_axis_tvalid && sent == len_q - PW'(1);
    accept = m_axis_tvalid && m_axis_tready;
    pop = accept && count != 2'd0;
    push = inflight && !(accept && count == 2'd0);
    state_n = state == IDLE ? (start ? (len_to_forwarder == '0 ? DONE : STREAM) : IDLE)
            : state == STREAM ? (accept && m_axis_tlast ? DONE : STREAM)
            : IDLE;
  end
  // packet counters and the two-entry return buffer
  always_ff @(posedge clk)
    if (rst) begin
      len_q <= '0;
      reads <= '0;
      sent <= '0;
      head <= 1'b0;
      count <= 2'd0;
      inflight <= 1'b0;
      hold <= 1'b0;
    end else begin
      hold <= state == DONE;
      inflight <= forwarder_rd_en;
      if (start) begin
        len_q <= len_to_forwarder;
        reads <= '0;
        sent <= '0;
      end
      if (forwarder_rd_en) reads <= reads + PW'(1);
      if (accept) sent <= sent + PW'(1);
      if (push) mem[head ^ count[0]] <= forwarder_rd_data;
      if (pop) head <= ~head;
      count <= count + 2'(push) - 2'(pop);
    end
`ifdef FWD_INORDER_SEL_EN
  // flips once per completed packet to steer the upstream combine tree
  always_ff @(posedge clk)
    if (rst) sel <= 1'b0;
    else if (state == DONE) sel <= ~sel;
`endif
endmodule
